uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Serialising transmit stage of the UART.
- Pops bytes from the TX FIFO, which is filled by the Avalon register block through tx_byte/tx_valid.
- Shifts each byte out on txd as an asynchronous serial frame: start, 8 data bits LSB first, optional parity, 1-3 stop bits.
- Contains its own bit-period counter, driven by cr_baud_limit. Frame format comes from the control register fields.

Parameters:
BAUD_W, 32, width of baud limit and bit-period counter
DATA_BITS, 8, data bits per frame; fixed, not reconfigurable at runtime

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
fifo_empty  input  1  TX FIFO empty flag
fifo_rdata  input  8  TX FIFO head word; show-ahead, valid while !fifo_empty
fifo_rd  output  1  pop strobe, one cycle per byte consumed
cr_pbit  input  1  parity enable
cr_ptype  input  1  parity type: 0 even, 1 odd
cr_sbit  input  2  stop bits: 00 = 1, 01 = 2, 10/11 = 3
cr_baud_limit  input  BAUD_W  bit period = cr_baud_limit+1 clk cycles
txd  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of the last stop bit

Behaviour:
- Reset (async, reset_n=0): state IDLE, txd=1, busy=0, tx_done=0, fifo_rd=0, counters cleared. Asserting reset mid-frame aborts the frame; txd returns high immediately.
- fifo_rd is combinational: fifo_rd = (state==IDLE) && !fifo_empty. Never asserted when fifo_empty=1.
- In the fifo_rd cycle the block latches:
  - fifo_rdata into the shift register
  - cr_pbit, cr_ptype, cr_sbit and cr_baud_limit into internal copies.
  Register changes during a frame do not affect it; they apply from the next frame.
- Parity bit = ^data when even, ~^data when odd. Computed from the latched byte.
- Bit-period counter:
  - Cleared at the fifo_rd cycle.
  - Counts 0..L, where L is the latched limit; a bit tick fires when count==L, then the counter wraps to 0.
  - L=0 gives a 1-clk bit. Full BAUD_W range is legal; no overflow beyond L.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1, busy=0. If !fifo_empty, go to START on the next clock.
  - START: txd=0 for L+1 cycles, then DATA.
  - DATA: txd=shift[0]. Shift right on each tick. After DATA_BITS ticks, go to PARITY if parity enabled, else STOP.
  - PARITY: txd=parity for one bit period, then STOP.
  - STOP: txd=1. Stop-bit counter counts ticks. After N stop bits (1/2/3): tx_done=1 for that cycle, return to IDLE.
- txd and busy are registered. txd changes only on state/bit boundaries; no glitches.
- busy=1 in every state except IDLE, including the cycle tx_done is high.
- Frame length in clk cycles: (1 + 8 + P + N) x (L+1), measured from the first txd=0 cycle to the last txd=1 stop cycle, where P is the parity bit count (0/1) and N the stop bit count.
- Back-to-back bytes: exactly one IDLE cycle (txd=1, fifo_rd=1) separates the last stop-bit cycle from the next start bit. This is a fixed, documented gap.
- FIFO empty during a frame has no effect. FIFO refilling during a frame is consumed at the next IDLE.
- Simultaneous tx_done and a non-empty FIFO: the FSM still passes through IDLE; no skipped or double pop.

Test Plan:
- L=3, pbit=0, sbit=00, FIFO holds 0xA5:
  - fifo_rd one cycle.
  - txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clk; frame 40 clk.
  - tx_done pulses once; busy high for 40 cycles.
- L=3, pbit=1, ptype=0, byte 0xA5 (4 ones) -> parity bit 0, frame 44 clk. Repeat with ptype=1 -> parity 1.
- L=0, sbit=10, pbit=0, byte 0x00 -> 1-clk bits; nine 0s, then three 1s; 12-clk frame. sbit=11 gives an identical result.
- FIFO holds 0x55 and 0x0F, L=1:
  - Two frames, separated by exactly 1 idle cycle.
  - Two fifo_rd pulses; then fifo_empty=1, block stays IDLE with txd=1.
- cr_baud_limit changed 3->7 and cr_pbit toggled mid-frame -> current frame unchanged; next frame uses 8-clk bits and the new parity setting.
- reset_n low in the DATA state -> txd=1, busy=0 asynchronously; after release, no fifo_rd until !fifo_empty; the next frame is well formed.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises TX FIFO bytes onto txd as start, data LSB first, optional parity, 1-3 stop bits
// ports: clk, reset_n (async, active low); fifo_empty/fifo_rdata/fifo_rd pop a show-ahead FIFO;
//        cr_pbit/cr_ptype/cr_sbit/cr_baud_limit give the frame format, latched once per frame at the pop;
//        txd serial line (idle high), busy frame in progress, tx_done one-cycle end-of-frame pulse
module uart_tx_engine #(
  parameter int BAUD_W    = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  output logic                 fifo_rd,
  input  logic                 cr_pbit,
  input  logic                 cr_ptype,
  input  logic [1:0]           cr_sbit,
  input  logic [BAUD_W-1:0]    cr_baud_limit,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0]    cnt_q, cnt_d, lim_q;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           sbit_q;
  logic                 pbit_q, par_q, txd_q, txd_d, busy_q, tick, last_stop;
  // bit_q counts data bits in DATA and stop bits in STOP; txd_d looks at the next state so txd is registered yet aligned
  always_comb begin
    tick      = cnt_q == lim_q;
    last_stop = bit_q == (sbit_q[1] ? 3'd2 : {2'b00, sbit_q[0]});
    fifo_rd   = reset_n && state_q == IDLE && !fifo_empty;
    tx_done   = state_q == STOP && tick && last_stop;
    cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + BAUD_W'(1);
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    case (state_q)
      IDLE:   state_d = fifo_rd ? START : IDLE;
      START: begin
        bit_d   = '0;
        state_d = tick ? DATA : START;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'(DATA_BITS - 1)) begin
          bit_d   = '0;
          state_d = pbit_q ? PARITY : STOP;
        end
      end
      PARITY: state_d = tick ? STOP : PARITY;
      STOP: if (tick) begin
        bit_d   = bit_q + 3'd1;
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    txd_d = state_d == START  ? 1'b0 :
            state_d == DATA   ? shift_d[0] :
            state_d == PARITY ? par_q : 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      bit_q   <= '0;
      sbit_q  <= '0;
      pbit_q  <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= fifo_rd ? fifo_rdata : shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= state_d != IDLE;
      if (fifo_rd) begin
        lim_q  <= cr_baud_limit;
        pbit_q <= cr_pbit;
        sbit_q <= cr_sbit;
        par_q  <= cr_ptype ^ (^fifo_rdata);
      end
    end
  end
  assign txd  = txd_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized self-checking bench comparing per-cycle txd/busy/fifo_rd/tx_done against a frame-level model
module tb_uart_tx_engine;
  logic        clk = 1'b0, reset_n = 1'b1, fifo_empty = 1'b1, fifo_rd;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        cr_pbit = 1'b0, cr_ptype = 1'b0;
  logic [1:0]  cr_sbit = 2'b00;
  logic [31:0] cr_baud_limit = 32'd0;
  logic        txd, busy, tx_done;
  int          tests = 0, failed = 0;
  logic [7:0]  fifo_q[$];
  logic [3:0]  cap_q[$], exp_q[$];
  always #5 clk = ~clk;
  uart_tx_engine #(.BAUD_W(32), .DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .cr_pbit(cr_pbit), .cr_ptype(cr_ptype), .cr_sbit(cr_sbit), .cr_baud_limit(cr_baud_limit),
    .txd(txd), .busy(busy), .tx_done(tx_done)
  );
  function automatic void refresh();
    fifo_empty = fifo_q.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endfunction
  always @(posedge clk) if (fifo_rd === 1'b1) begin
    #1;
    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  end
  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask
  task automatic set_cfg(input logic pb, input logic pt, input logic [1:0] sb, input int lim);
    cr_pbit = pb; cr_ptype = pt; cr_sbit = sb; cr_baud_limit = 32'(lim);
  endtask
  // model: one idle pop cycle, then the frame's bit list, each bit held lim+1 cycles; sample = {txd,busy,fifo_rd,tx_done}
  task automatic add_frame(input logic [7:0] d, input logic pb, input logic pt, input logic [1:0] sb, input int lim);
    logic bits[$];
    int   n;
    n = (sb == 2'b00) ? 1 : (sb == 2'b01) ? 2 : 3;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pb) bits.push_back((($countones(d) % 2) == 1) ^ pt);
    for (int i = 0; i < n; i++) bits.push_back(1'b1);
    exp_q.push_back(4'b1010);
    foreach (bits[j]) for (int k = 0; k <= lim; k++)
      exp_q.push_back({bits[j], 2'b10, logic'(j == bits.size() - 1 && k == lim)});
  endtask
  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(4'b1000);
  endtask
  task automatic capture();
    cap_q.delete();
    repeat (exp_q.size()) begin
      #1 cap_q.push_back({txd, busy, fifo_rd, tx_done});
      @(negedge clk);
    end
  endtask
  function automatic int first_diff();
    foreach (cap_q[i]) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction
  function automatic int cnt(input int b);
    int c = 0;
    foreach (cap_q[i]) if (cap_q[i][b] === 1'b1) c++;
    return c;
  endfunction
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1 tests++;
    if ({txd, busy, fifo_rd, tx_done} !== 4'b1000) begin
      failed++; $display("FAIL reset_state got %b want 1000", {txd, busy, fifo_rd, tx_done});
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 tests++;
    if ({txd, busy, fifo_rd, tx_done} !== 4'b1000) begin
      failed++; $display("FAIL idle_after_reset got %b want 1000", {txd, busy, fifo_rd, tx_done});
    end
    @(negedge clk);
  endtask
  task automatic test_basic();
    logic [9:0] got;
    int d;
    set_cfg(0, 0, 2'b00, 3);
    exp_q.delete(); add_frame(8'hA5, 0, 0, 2'b00, 3); add_idle(3);
    push(8'hA5); capture();
    d = first_diff(); tests++;
    if (d != -1) begin failed++; $display("FAIL basic_wave cycle %0d got %b want %b", d, cap_q[d], exp_q[d]); end
    for (int i = 0; i < 10; i++) got[i] = cap_q[1 + 4 * i][3];
    tests++;
    if (got !== 10'b1101001010) begin failed++; $display("FAIL basic_bits got %b want 1101001010", got); end
    tests++;
    if (cnt(2) != 40) begin failed++; $display("FAIL basic_busy_len got %0d want 40", cnt(2)); end
    tests++;
    if (cnt(1) != 1) begin failed++; $display("FAIL basic_pops got %0d want 1", cnt(1)); end
    tests++;
    if (cnt(0) != 1) begin failed++; $display("FAIL basic_done got %0d want 1", cnt(0)); end
  endtask
  task automatic test_parity();
    int d;
    for (int pt = 0; pt < 2; pt++) begin
      set_cfg(1, pt[0], 2'b00, 3);
      exp_q.delete(); add_frame(8'hA5, 1, pt[0], 2'b00, 3); add_idle(2);
      push(8'hA5); capture();
      d = first_diff(); tests++;
      if (d != -1) begin failed++; $display("FAIL parity%0d_wave cycle %0d got %b want %b", pt, d, cap_q[d], exp_q[d]); end
      tests++;
      if (cap_q[37][3] !== pt[0]) begin failed++; $display("FAIL parity%0d_bit got %b want %b", pt, cap_q[37][3], pt[0]); end
      tests++;
      if (cnt(2) != 44) begin failed++; $display("FAIL parity%0d_len got %0d want 44", pt, cnt(2)); end
    end
  endtask
  task automatic test_stop3();
    int d;
    for (int sb = 2; sb < 4; sb++) begin
      set_cfg(0, 0, sb[1:0], 0);
      exp_q.delete(); add_frame(8'h00, 0, 0, sb[1:0], 0); add_idle(2);
      push(8'h00); capture();
      d = first_diff(); tests++;
      if (d != -1) begin failed++; $display("FAIL stop3_sb%0d_wave cycle %0d got %b want %b", sb, d, cap_q[d], exp_q[d]); end
      tests++;
      if (cnt(2) != 12) begin failed++; $display("FAIL stop3_sb%0d_len got %0d want 12", sb, cnt(2)); end
    end
  endtask
  task automatic test_back_to_back();
    int d;
    set_cfg(0, 0, 2'b00, 1);
    exp_q.delete(); add_frame(8'h55, 0, 0, 2'b00, 1); add_frame(8'h0F, 0, 0, 2'b00, 1); add_idle(4);
    push(8'h55); push(8'h0F); capture();
    d = first_diff(); tests++;
    if (d != -1) begin failed++; $display("FAIL b2b_wave cycle %0d got %b want %b", d, cap_q[d], exp_q[d]); end
    tests++;
    if (cnt(1) != 2) begin failed++; $display("FAIL b2b_pops got %0d want 2", cnt(1)); end
    tests++;
    if (cnt(2) != 40) begin failed++; $display("FAIL b2b_busy_len got %0d want 40", cnt(2)); end
  endtask
  task automatic test_cfg_change();
    logic [7:0] a, b;
    logic       pt;
    int         d;
    a = 8'($urandom); b = 8'($urandom); pt = 1'($urandom);
    set_cfg(0, 0, 2'b00, 3);
    exp_q.delete(); add_frame(a, 0, 0, 2'b00, 3); add_frame(b, 1, pt, 2'b00, 7); add_idle(2);
    push(a); push(b);
    fork
      capture();
      begin repeat (12) @(negedge clk); set_cfg(1, pt, 2'b00, 7); end
    join
    d = first_diff(); tests++;
    if (d != -1) begin failed++; $display("FAIL cfg_change_wave cycle %0d got %b want %b", d, cap_q[d], exp_q[d]); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] b;
    logic       ok = 1'b1;
    int         d;
    set_cfg(0, 0, 2'b00, 3);
    push(8'h00);
    repeat (11) @(negedge clk);
    #1 tests++;
    if ({txd, busy} !== 2'b01) begin failed++; $display("FAIL mid_pre_reset got %b want 01", {txd, busy}); end
    reset_n = 1'b0;
    #1 tests++;
    if ({txd, busy, fifo_rd, tx_done} !== 4'b1000) begin
      failed++; $display("FAIL mid_reset_async got %b want 1000", {txd, busy, fifo_rd, tx_done});
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1 if (fifo_rd !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin failed++; $display("FAIL mid_post_reset_idle got not-idle want idle"); end
    @(negedge clk);
    b = 8'($urandom);
    exp_q.delete(); add_frame(b, 0, 0, 2'b00, 3); add_idle(2);
    push(b); capture();
    d = first_diff(); tests++;
    if (d != -1) begin failed++; $display("FAIL mid_next_frame cycle %0d got %b want %b", d, cap_q[d], exp_q[d]); end
  endtask
  task automatic test_random();
    logic [7:0] b;
    logic [1:0] sb;
    logic       pb, pt;
    int         lim, n, d;
    for (int it = 0; it < 6; it++) begin
      lim = $urandom_range(0, 3); n = $urandom_range(1, 3);
      pb = 1'($urandom); pt = 1'($urandom); sb = 2'($urandom);
      set_cfg(pb, pt, sb, lim);
      exp_q.delete();
      repeat (n) begin b = 8'($urandom); push(b); add_frame(b, pb, pt, sb, lim); end
      add_idle(2);
      capture();
      d = first_diff(); tests++;
      if (d != -1) begin failed++; $display("FAIL random%0d cycle %0d got %b want %b", it, d, cap_q[d], exp_q[d]); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop3();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
